network_tx_scheduler: RTL

Strict-priority, gate-aware packet scheduler that sequences the network transmit byte pipeline ahead of the PTP transparent-clock update stage. It selects one of three egress queues (TS, RC, BE), pulls the selected packet byte-by-byte from that queue's buffer, and emits a 9-bit stream whose bit 8 marks the first byte of each packet. It enforces the inter-packet idle gap that the downstream stage needs to re-arm its packet parser.

---
 rtl/network_tx_sched_pkg.sv | 31 +++
 rtl/tx_priority_select.sv | 53 +++++
 rtl/network_tx_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/network_tx_sched_pkg.sv
// Shared constants and types for the strict-priority network transmit scheduler.
package network_tx_sched_pkg;

  localparam logic [1:0] Q_TS = 2'd0;
  localparam logic [1:0] Q_RC = 2'd1;
  localparam logic [1:0] Q_BE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam logic [3:0] IFG_STD = 4'd12;
  localparam logic [3:0] IFG_MIN = 4'd2;

  localparam int unsigned MIN_LEN_DEF = 60;
  localparam int unsigned MAX_LEN_DEF = 1536;

  function automatic logic [2:0] q_onehot(input logic [1:0] q);
    logic [2:0] oh;
    case (q)
      Q_TS:    oh = 3'b001;
      Q_RC:    oh = 3'b010;
      Q_BE:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/tx_priority_select.sv
// Combinational fixed-priority (TS > RC > BE) queue picker with length legality check.
module tx_priority_select
  import network_tx_sched_pkg::*;
#(
  parameter int unsigned MIN_LEN = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic [2:0]  iv_req,
  input  logic [2:0]  iv_gate,
  input  logic [10:0] iv_len0,
  input  logic [10:0] iv_len1,
  input  logic [10:0] iv_len2,
  output logic        o_valid,
  output logic [1:0]  ov_sel,
  output logic [10:0] ov_len,
  output logic        o_illegal
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  logic [2:0] elig_s;

  // Pick the highest eligible queue and flag an out-of-range head length.
  always_comb begin
    elig_s    = iv_req & iv_gate;
    o_valid   = 1'b0;
    ov_sel    = Q_TS;
    ov_len    = 11'd0;
    o_illegal = 1'b0;
    if (elig_s[0]) begin
      o_valid = 1'b1;
      ov_sel  = Q_TS;
      ov_len  = iv_len0;
    end else if (elig_s[1]) begin
      o_valid = 1'b1;
      ov_sel  = Q_RC;
      ov_len  = iv_len1;
    end else if (elig_s[2]) begin
      o_valid = 1'b1;
      ov_sel  = Q_BE;
      ov_len  = iv_len2;
    end else begin
      o_valid = 1'b0;
    end
    if (o_valid && ((ov_len < MIN_L) || (ov_len > MAX_L))) begin
      o_illegal = 1'b1;
    end else begin
      o_illegal = 1'b0;
    end
  end

endmodule

// File: rtl/network_tx_scheduler.sv
// Gate-aware strict-priority packet scheduler feeding the PTP transparent-clock stage.
// NETWORK_TX_IFG_EN selects the 12-cycle inter-frame gap; otherwise the gap is 2 cycles.
module network_tx_scheduler
  import network_tx_sched_pkg::*;
#(
  parameter int unsigned MIN_LEN = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  iv_req,
  input  logic [10:0] iv_len0,
  input  logic [10:0] iv_len1,
  input  logic [10:0] iv_len2,
  input  logic [2:0]  iv_gate,
  output logic [2:0]  ov_rd,
  input  logic [7:0]  iv_data0,
  input  logic [7:0]  iv_data1,
  input  logic [7:0]  iv_data2,
  output logic [2:0]  ov_done,
  output logic [2:0]  ov_discard,
  output logic [8:0]  ov_pkt_data,
  output logic        o_pkt_data_wr
);

`ifdef NETWORK_TX_IFG_EN
  localparam logic [3:0] IFG = IFG_STD;
`else
  localparam logic [3:0] IFG = IFG_MIN;
`endif
  // GAP spans IFG-1 cycles; the counter runs from IFG-2 down to 0.
  localparam logic [3:0] GAP_LOAD = IFG - 4'd2;

  logic        sel_valid_s;
  logic [1:0]  sel_idx_s;
  logic [10:0] sel_len_s;
  logic        sel_illegal_s;

  tx_state_e   state_q, state_d;
  logic [10:0] len_cnt_q, len_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [1:0]  q_idx_q, q_idx_d;
  logic [1:0]  q_idx_d1_q, q_idx_d1_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  done_q, done_d;
  logic [2:0]  discard_q, discard_d;
  logic        first_q, first_d;
  logic        rd_d1_q, rd_d1_d;
  logic        first_d1_q, first_d1_d;
  logic [8:0]  pkt_data_q, pkt_data_d;
  logic        pkt_wr_q, pkt_wr_d;
  logic [7:0]  byte_sel_s;

  tx_priority_select #(
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN)
  ) u_select (
    .iv_req   (iv_req),
    .iv_gate  (iv_gate),
    .iv_len0  (iv_len0),
    .iv_len1  (iv_len1),
    .iv_len2  (iv_len2),
    .o_valid  (sel_valid_s),
    .ov_sel   (sel_idx_s),
    .ov_len   (sel_len_s),
    .o_illegal(sel_illegal_s)
  );

  // State, counters and the registered output pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      len_cnt_q  <= 11'd0;
      gap_cnt_q  <= 4'd0;
      q_idx_q    <= 2'd0;
      q_idx_d1_q <= 2'd0;
      rd_q       <= 3'b000;
      done_q     <= 3'b000;
      discard_q  <= 3'b000;
      first_q    <= 1'b0;
      rd_d1_q    <= 1'b0;
      first_d1_q <= 1'b0;
      pkt_data_q <= 9'd0;
      pkt_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_cnt_q  <= len_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      q_idx_q    <= q_idx_d;
      q_idx_d1_q <= q_idx_d1_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
      discard_q  <= discard_d;
      first_q    <= first_d;
      rd_d1_q    <= rd_d1_d;
      first_d1_q <= first_d1_d;
      pkt_data_q <= pkt_data_d;
      pkt_wr_q   <= pkt_wr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_valid_s && !sel_illegal_s) state_d = READ;
        else                               state_d = IDLE;
      end
      READ: begin
        if (len_cnt_q <= 11'd1) state_d = GAP;
        else                    state_d = READ;
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) state_d = IDLE;
        else                   state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, read strobes, done/discard pulses and counters.
  always_comb begin
    len_cnt_d = len_cnt_q;
    gap_cnt_d = gap_cnt_q;
    q_idx_d   = q_idx_q;
    rd_d      = 3'b000;
    done_d    = 3'b000;
    discard_d = 3'b000;
    first_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid_s && sel_illegal_s) begin
          discard_d = q_onehot(sel_idx_s);
        end else if (sel_valid_s) begin
          q_idx_d   = sel_idx_s;
          len_cnt_d = sel_len_s;
          rd_d      = q_onehot(sel_idx_s);
          first_d   = 1'b1;
          done_d    = (sel_len_s == 11'd1) ? q_onehot(sel_idx_s) : 3'b000;
        end else begin
          len_cnt_d = len_cnt_q;
        end
      end
      READ: begin
        // len_cnt holds the reads still owed including the one on ov_rd now.
        len_cnt_d = len_cnt_q - 11'd1;
        if (len_cnt_q > 11'd1) begin
          rd_d   = q_onehot(q_idx_q);
          done_d = (len_cnt_q == 11'd2) ? q_onehot(q_idx_q) : 3'b000;
        end else begin
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt_q != 4'd0) gap_cnt_d = gap_cnt_q - 4'd1;
        else                   gap_cnt_d = 4'd0;
      end
      default: len_cnt_d = 11'd0;
    endcase
  end

  // Output byte stage: buffer data arrives one cycle after the strobe.
  always_comb begin
    rd_d1_d    = |rd_q;
    first_d1_d = first_q;
    q_idx_d1_d = q_idx_q;
    case (q_idx_d1_q)
      Q_TS:    byte_sel_s = iv_data0;
      Q_RC:    byte_sel_s = iv_data1;
      Q_BE:    byte_sel_s = iv_data2;
      default: byte_sel_s = 8'd0;
    endcase
    if (rd_d1_q) begin
      pkt_wr_d   = 1'b1;
      pkt_data_d = {first_d1_q, byte_sel_s};
    end else begin
      pkt_wr_d   = 1'b0;
      pkt_data_d = 9'd0;
    end
  end

  assign ov_rd         = rd_q;
  assign ov_done       = done_q;
  assign ov_discard    = discard_q;
  assign ov_pkt_data   = pkt_data_q;
  assign o_pkt_data_wr = pkt_wr_q;

endmodule
